// File: rtl/karatsuba_pkg.sv
// Shared definitions for the sequential Karatsuba multiplier: state encodings and half-width helper.
// Optional signed operation is enabled in the top by defining KARATSUBA_SIGNED_EN.
package karatsuba_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_LOAD    = 3'b001,
    S_MUL_HI  = 3'b010,
    S_MUL_LO  = 3'b011,
    S_MUL_MID = 3'b100,
    S_COMBINE = 3'b101,
    S_DONE    = 3'b110
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_H     = DEFAULT_WIDTH / 2;

  function automatic int unsigned half_width(input int unsigned width);
    return width / 2;
  endfunction

endpackage

// File: rtl/karatsuba_half_mul.sv
// Combinational (H+1)x(H+1) -> 2H+2 unsigned multiplier shared by all three Karatsuba partial products.
module karatsuba_half_mul
  import karatsuba_pkg::*;
#(
  parameter int unsigned H = DEFAULT_H
) (
  input  logic [H:0]     a,
  input  logic [H:0]     b,
  output logic [2*H+1:0] prod
);

  assign prod = {{(H+1){1'b0}}, a} * {{(H+1){1'b0}}, b};

endmodule

// File: rtl/karatsuba_seq_mul.sv
// Multi-cycle WIDTHxWIDTH Karatsuba multiplier with START/READY/DONE handshake and visible state.
// Define KARATSUBA_SIGNED_EN to add the signed_mode input for two's-complement operands.
module karatsuba_seq_mul
  import karatsuba_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef KARATSUBA_SIGNED_EN
  input  logic               signed_mode,
`endif
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic [2:0]         state
);

  localparam int unsigned H  = half_width(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned MW = 2 * H + 2;

  state_t state_q, state_d;
  logic   accept;

  logic [WIDTH-1:0] x_q, y_q;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic             neg_load, neg_q;
  logic [H-1:0]     xh_q, xl_q, yh_q, yl_q;
  logic [H:0]       xs_q, ys_q;
  logic [2*H-1:0]   z2_q, z0_q;
  logic [MW-1:0]    m_q;

  logic [H:0]       mul_a, mul_b;
  logic [MW-1:0]    mul_prod;
  logic [MW-1:0]    z1;
  logic [PW-1:0]    p_sum, p_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output is given a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) begin
          accept  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD:    state_d = S_MUL_HI;
      S_MUL_HI:  state_d = S_MUL_LO;
      S_MUL_LO:  state_d = S_MUL_MID;
      S_MUL_MID: state_d = S_COMBINE;
      S_COMBINE: state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  assign state = state_q;

`ifdef KARATSUBA_SIGNED_EN
  logic mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mode_q <= 1'b0;
    else if (accept) mode_q <= signed_mode;
  end

  // Magnitude of the most-negative operand is 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    x_mag    = (mode_q && x_q[WIDTH-1]) ? (~x_q + WIDTH'(1)) : x_q;
    y_mag    = (mode_q && y_q[WIDTH-1]) ? (~y_q + WIDTH'(1)) : y_q;
    neg_load = mode_q & (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
  end
`else
  assign x_mag    = x_q;
  assign y_mag    = y_q;
  assign neg_load = 1'b0;
`endif

  // Shared sub-multiplier operands are selected by the current state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MUL_HI: begin
        mul_a = {1'b0, xh_q};
        mul_b = {1'b0, yh_q};
      end
      S_MUL_LO: begin
        mul_a = {1'b0, xl_q};
        mul_b = {1'b0, yl_q};
      end
      S_MUL_MID: begin
        mul_a = xs_q;
        mul_b = ys_q;
      end
      default: ;
    endcase
  end

  karatsuba_half_mul #(.H(H)) u_half_mul (
    .a    (mul_a),
    .b    (mul_b),
    .prod (mul_prod)
  );

  // z2 and z0 occupy disjoint halves, so their placement is a concatenation.
  assign z1     = m_q - MW'(z2_q) - MW'(z0_q);
  assign p_sum  = {z2_q, z0_q} + (PW'(z1) << H);
  assign p_next = neg_q ? (~p_sum + PW'(1)) : p_sum;

  // NOTE: every datapath register is reset so an aborted operation leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      xh_q  <= '0;
      xl_q  <= '0;
      yh_q  <= '0;
      yl_q  <= '0;
      xs_q  <= '0;
      ys_q  <= '0;
      neg_q <= 1'b0;
      z2_q  <= '0;
      z0_q  <= '0;
      m_q   <= '0;
      p     <= '0;
    end else begin
      if (accept) begin
        x_q <= x;
        y_q <= y;
      end
      case (state_q)
        S_LOAD: begin
          xh_q  <= x_mag[WIDTH-1:H];
          xl_q  <= x_mag[H-1:0];
          yh_q  <= y_mag[WIDTH-1:H];
          yl_q  <= y_mag[H-1:0];
          xs_q  <= {1'b0, x_mag[WIDTH-1:H]} + {1'b0, x_mag[H-1:0]};
          ys_q  <= {1'b0, y_mag[WIDTH-1:H]} + {1'b0, y_mag[H-1:0]};
          neg_q <= neg_load;
        end
        S_MUL_HI:  z2_q <= mul_prod[2*H-1:0];
        S_MUL_LO:  z0_q <= mul_prod[2*H-1:0];
        S_MUL_MID: m_q  <= mul_prod;
        S_COMBINE: p    <= p_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_seq_mul.sv
// Scoreboard bench for karatsuba_seq_mul: directed products, handshake, abort and back-to-back cases.
module tb_karatsuba_seq_mul;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
`ifdef KARATSUBA_SIGNED_EN
  logic           signed_mode;
`endif
  logic [W-1:0]   x, y;
  logic           ready, busy, done;
  logic [2*W-1:0] p;
  logic [2:0]     state;

  logic [2*W-1:0] sb_q[$];
  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  karatsuba_seq_mul #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef KARATSUBA_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .x           (x),
    .y           (y),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .p           (p),
    .state       (state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      n_done++;
      check("done_has_expect", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) check("product", p, sb_q.pop_front());
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", ready, 1);
  endtask

  // Called at a negedge with ready=1; returns 1ns after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input bit push);
    x     = a;
    y     = b;
    start = 1'b1;
    if (push) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_snap;
    logic [2:0] walk [7];
    walk[0] = 3'b001; walk[1] = 3'b010; walk[2] = 3'b011; walk[3] = 3'b100;
    walk[4] = 3'b101; walk[5] = 3'b110; walk[6] = 3'b000;

    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;
`ifdef KARATSUBA_SIGNED_EN
    signed_mode = 1'b0;
`endif
    #12;
    @(negedge clk);
    rst = 1'b0;

    check("reset_state", state, 0);
    check("reset_ready", ready, 1);
    check("reset_busy",  busy,  0);
    check("reset_done",  done,  0);
    check("reset_p",     p,     0);

    // State walk and 6-cycle latency; operand changes after acceptance must not matter.
    issue(16'h1234, 16'h5678, 32'h0626_0060, 1'b1);
    x = 16'hDEAD;
    y = 16'hBEEF;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("walk_state_%0d", i), state, walk[i]);
      check($sformatf("walk_done_%0d", i), done, (i == 5) ? 1 : 0);
    end
    check("ready_after_done", ready, 1);

    wait_idle();
    issue(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1);
    wait_idle();
    issue(16'h0000, 16'hABCD, 32'h0000_0000, 1'b1);
    wait_idle();

    // START while busy (in MUL_LO) is ignored.
    issue(16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b1);
    repeat (3) @(negedge clk);
    check("busy_state_mul_lo", state, 3);
    check("busy_flag", busy, 1);
    check("busy_ready", ready, 0);
    x     = 16'hAAAA;
    y     = 16'h5555;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    check("p_held_after_done", p, 32'h0000_FFFF);

    // Reset in MUL_MID discards the operation immediately.
    done_snap = n_done;
    issue(16'h1234, 16'h5678, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    check("abort_in_mul_mid", state, 4);
    rst = 1'b1;
    #1;
    check("abort_state", state, 0);
    check("abort_p",     p,     0);
    check("abort_ready", ready, 1);
    check("abort_done",  done,  0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", n_done, done_snap);
    issue(16'hABCD, 16'h0002, 32'h0001_579A, 1'b1);
    wait_idle();

    // START held high: one product every 7 cycles.
    done_snap = n_done;
    x     = 16'd3;
    y     = 16'd5;
    start = 1'b1;
    repeat (3) sb_q.push_back(32'd15);
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      check($sformatf("held_done_c%0d", c), done, ((c % 7) == 5) ? 1 : 0);
      if (c == 14) start = 1'b0;
    end
    wait_idle();
    check("held_done_count", n_done - done_snap, 3);

`ifdef KARATSUBA_SIGNED_EN
    signed_mode = 1'b1;
    issue(16'hFFFE, 16'h0003, 32'hFFFF_FFFA, 1'b1);
    wait_idle();
    issue(16'h8000, 16'h8000, 32'h4000_0000, 1'b1);
    wait_idle();
    signed_mode = 1'b0;
    issue(16'hFFFE, 16'h0003, 32'h0002_FFFA, 1'b1);
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/karatsuba_seq_mul.md
# karatsuba_seq_mul

- Parametrised, registered successor of the 3-bit Karatsuba controller next-state logic.
- Multi-cycle WIDTH×WIDTH multiplier: a clocked FSM reuses one (H+1)×(H+1) sub-multiplier (H = WIDTH/2) for the three Karatsuba partial products, then combines them.
- Sits between operand producers and result consumers in the multiplier datapath.
- Uses a START/READY/DONE handshake and exposes its state for debug.

## Interface
- WIDTH, 16: operand width. Must be even and ≥ 4.
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  request. Accepted only when READY=1.
- X  in  WIDTH  multiplicand. Sampled on the accepting edge.
- Y  in  WIDTH  multiplier. Sampled on the accepting edge.
- READY  out  1  high only in IDLE
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse. P is valid in that cycle.
- P  out  2*WIDTH  product. Held until the next accepted START.
- STATE  out  3  current state encoding (E0 = STATE[2], E1 = STATE[1], E2 = STATE[0])

## Operation
- States and encodings: IDLE 000, LOAD 001, MUL_HI 010, MUL_LO 011, MUL_MID 100, COMBINE 101, DONE 110. Code 111 is illegal and returns to IDLE.
- IDLE → LOAD when START=1. Otherwise stay in IDLE.
- In LOAD:
  - split into xh/xl, yh/yl (H bits each)
  - form xs = xh+xl and ys = yh+yl, each H+1 bits, no truncation
- LOAD → MUL_HI: z2 = xh·yh, 2H bits.
- MUL_HI → MUL_LO: z0 = xl·yl, 2H bits.
- MUL_LO → MUL_MID: m = xs·ys, 2H+2 bits.
- MUL_MID → COMBINE:
  - z1 = m − z2 − z0, computed at 2H+2 bits; always ≥ 0
  - P = (z2 << WIDTH) + (z1 << H) + z0, truncated to 2*WIDTH bits; the true value never exceeds this
- COMBINE → DONE → IDLE, unconditional.
- All three products pass through the single shared sub-multiplier. Its operands are muxed by state.
- START while BUSY=1 is ignored: no capture, no queueing.
- START held high across DONE is accepted in the following IDLE cycle.
- X/Y changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, READY=1, BUSY=0, DONE=0, P=0, STATE=000. All internal registers are cleared.
- Reset asserted mid-operation: the state returns to IDLE immediately (asynchronously). The operation is discarded, P=0, and no DONE is issued.
- START accepted at edge k:
  - LOAD from k
  - P registered at edge k+5
  - DONE=1 during cycle k+5..k+6
  - READY=1 again from edge k+6
- Latency: 6 cycles from acceptance to DONE. Minimum initiation interval: 7 cycles.
- P changes only at the COMBINE→DONE edge and on reset. All outputs are registered or decoded from registered state.

## Configuration
- KARATSUBA_SIGNED_EN defined:
  - adds input SIGNED_MODE (1 bit, sampled with X/Y)
  - when SIGNED_MODE=1: operands are two's complement; LOAD takes magnitudes and records sign = X[MSB]^Y[MSB]; COMBINE two's-complement-negates P when sign=1
  - the most-negative operand has magnitude 2^(WIDTH−1), which is representable unsigned
  - latency is unchanged
- Not defined: no SIGNED_MODE port; unsigned only.

## Structure
- Package karatsuba_pkg holds:
  - the 3-bit state encodings: S_IDLE, S_LOAD, S_MUL_HI, S_MUL_LO, S_MUL_MID, S_COMBINE, S_DONE
  - a helper constant for H
- Sub-module karatsuba_half_mul: purely combinational (H+1)×(H+1) → 2H+2 unsigned multiplier, instantiated once.
- The FSM next-state logic is written as a separate combinational block. STATE is observable so that benches can check transitions directly.

## Test plan
- WIDTH=16, X=0x1234, Y=0x5678, START one cycle → STATE walks 000,001,010,011,100,101,110,000. DONE=1 exactly 6 cycles after acceptance with P=0x06260060.
- X=0xFFFF, Y=0xFFFF → P=0xFFFE0001. Also X=0, Y=0xABCD → P=0.
- START pulsed during MUL_LO with different X/Y → ignored. Original product delivered; DONE is the only pulse.
- RST asserted in MUL_MID → STATE=000, P=0, READY=1 at once, no DONE. A new request afterwards gives the correct product.
- START held high continuously with X=3, Y=5 → P=15 every 7 cycles, one DONE per operation.
- KARATSUBA_SIGNED_EN, SIGNED_MODE=1:
  - X=0xFFFE (−2), Y=0x0003 → P=0xFFFFFFFA
  - X=0x8000, Y=0x8000 → P=0x40000000
